// File: rtl/pfpu_regf_ctl_if.sv
// rtl/pfpu_regf_ctl_if.sv - host CSR access bus into the PFPU register-file sequencer
//
// Purpose: groups the host-side CSR request/response signals of pfpu_regf_ctl.
// Ports (signals):
//   csr_req   host -> ctl  access request, level, held until csr_ack
//   csr_we    host -> ctl  1=write 0=read, stable while csr_req
//   csr_addr  host -> ctl  register index, stable while csr_req
//   csr_wdat  host -> ctl  write data, stable while csr_req
//   csr_ack   ctl -> host  one-cycle completion pulse
//   csr_rdat  ctl -> host  read data, valid with csr_ack, held until next read ack
//   csr_err   ctl -> host  pulses with csr_ack when the access was aborted
// Modports: master = CSR decoder side, slave = pfpu_regf_ctl side.

interface pfpu_regf_ctl_if;
   logic        csr_req;
   logic        csr_we;
   logic [6:0]  csr_addr;
   logic [31:0] csr_wdat;
   logic        csr_ack;
   logic [31:0] csr_rdat;
   logic        csr_err;

   modport master (
      output csr_req, csr_we, csr_addr, csr_wdat,
      input  csr_ack, csr_rdat, csr_err
   );

   modport slave (
      input  csr_req, csr_we, csr_addr, csr_wdat,
      output csr_ack, csr_rdat, csr_err
   );
endinterface

// File: rtl/pfpu_regf_ctl.sv
// rtl/pfpu_regf_ctl.sv - PFPU register-file CSR port sequencer with hardware clear
//
// Purpose: serialises host CSR reads/writes against ALU activity on the
// pfpu_regf c_* port and runs a hardware clear of R[CLR_FIRST..CLR_LAST].
// regf_busy tells the PFPU control FSM to hold off program start.
// Optional feature macro: PFPU_REGF_CTL_TIMEOUT_EN - a request waiting on
// alu_busy for TIMEOUT cycles is acknowledged with csr_err and no access.
// Ports:
//   sys_clk, sys_rst      clock, asynchronous active-high reset
//   csr (slave)           host CSR request/response bus
//   alu_busy              PFPU program running / pipeline writes in flight
//   clr_start             pulse: request clear of R[CLR_FIRST..CLR_LAST]
//   clr_busy              clear sequence in progress
//   regf_busy             controller owns the regfile port
//   c_en/c_addr/c_w_en/c_di  regfile port drive
//   c_do                  regfile read data, valid one cycle after c_en

module pfpu_regf_ctl #(
   parameter int CLR_FIRST = 2,
   parameter int CLR_LAST  = 127,
   parameter int TIMEOUT   = 1023
) (
   input  logic           sys_clk,
   input  logic           sys_rst,
   pfpu_regf_ctl_if.slave csr,
   input  logic           alu_busy,
   input  logic           clr_start,
   output logic           clr_busy,
   output logic           regf_busy,
   output logic           c_en,
   output logic [6:0]     c_addr,
   output logic           c_w_en,
   output logic [31:0]    c_di,
   input  logic [31:0]    c_do
);

   localparam logic [6:0] CLR_FIRST_A = 7'(CLR_FIRST);
   localparam logic [6:0] CLR_LAST_A  = 7'(CLR_LAST);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      RD_ADDR = 3'd1,
      RD_DATA = 3'd2,
      WR      = 3'd3,
      CLEAR   = 3'd4,
      ACK     = 3'd5
   } state_t;

   state_t      state;
   state_t      state_nxt;
   logic        pend_clr;
   logic        pend_clr_nxt;
   logic        clr_want;
   logic        tmo_hit;

   logic        csr_ack_nxt;
   logic        csr_err_nxt;
   logic [31:0] csr_rdat_nxt;
   logic        clr_busy_nxt;
   logic        regf_busy_nxt;
   logic        c_en_nxt;
   logic        c_w_en_nxt;
   logic [6:0]  c_addr_nxt;
   logic [31:0] c_di_nxt;

   // A clr_start arriving in IDLE counts as already pending, so it wins
   // against a csr_req sampled in the same cycle.
   assign clr_want = pend_clr | clr_start;

`ifdef PFPU_REGF_CTL_TIMEOUT_EN
   localparam int TMO_W = $clog2(TIMEOUT + 1);

   logic [TMO_W-1:0] tmo_cnt;
   logic [TMO_W-1:0] tmo_cnt_nxt;

   // Fires on the cycle the wait count would reach TIMEOUT.
   assign tmo_hit = csr.csr_req && alu_busy && (tmo_cnt == TMO_W'(TIMEOUT - 1));

   always_comb begin
      tmo_cnt_nxt = tmo_cnt;
      if (state_nxt == ACK)
         tmo_cnt_nxt = '0;
      else if ((state == IDLE) && csr.csr_req && alu_busy)
         tmo_cnt_nxt = tmo_cnt + 1'b1;
   end

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst)
         tmo_cnt <= '0;
      else
         tmo_cnt <= tmo_cnt_nxt;
   end
`else
   assign tmo_hit = 1'b0;
`endif

   // State register
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (!alu_busy) begin
               if (clr_want)
                  state_nxt = CLEAR;
               else if (csr.csr_req)
                  state_nxt = csr.csr_we ? WR : RD_ADDR;
            end else if (tmo_hit) begin
               state_nxt = ACK;
            end
         end
         RD_ADDR: state_nxt = RD_DATA;
         RD_DATA: state_nxt = ACK;
         WR:      state_nxt = ACK;
         CLEAR:   if (c_addr == CLR_LAST_A) state_nxt = IDLE;
         ACK:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Output logic: computes the registered output values for the next state
   always_comb begin
      csr_ack_nxt   = (state_nxt == ACK);
      clr_busy_nxt  = (state_nxt == CLEAR);
      regf_busy_nxt = (state_nxt != IDLE);
      c_en_nxt      = (state_nxt == RD_ADDR) || (state_nxt == WR) || (state_nxt == CLEAR);
      c_w_en_nxt    = (state_nxt == WR) || (state_nxt == CLEAR);
      c_addr_nxt    = c_addr;
      c_di_nxt      = c_di;
      csr_rdat_nxt  = csr.csr_rdat;
`ifdef PFPU_REGF_CTL_TIMEOUT_EN
      // The only direct IDLE->ACK path is the timeout abort.
      csr_err_nxt   = (state == IDLE) && (state_nxt == ACK);
`else
      csr_err_nxt   = 1'b0;
`endif

      case (state_nxt)
         RD_ADDR: c_addr_nxt = csr.csr_addr;
         WR: begin
            c_addr_nxt = csr.csr_addr;
            c_di_nxt   = csr.csr_wdat;
         end
         CLEAR: begin
            // c_addr doubles as the clear counter; it parks on CLR_LAST.
            c_addr_nxt = (state == CLEAR) ? c_addr + 7'd1 : CLR_FIRST_A;
            c_di_nxt   = '0;
         end
         default: ;
      endcase

      // c_do answers the address presented in RD_ADDR during RD_DATA.
      if (state == RD_DATA)
         csr_rdat_nxt = c_do;

      if (state == CLEAR)
         pend_clr_nxt = 1'b0;
      else if (state_nxt == CLEAR)
         pend_clr_nxt = 1'b0;
      else
         pend_clr_nxt = clr_want;
   end

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         pend_clr     <= 1'b0;
         csr.csr_ack  <= 1'b0;
         csr.csr_err  <= 1'b0;
         csr.csr_rdat <= '0;
         clr_busy     <= 1'b0;
         regf_busy    <= 1'b0;
         c_en         <= 1'b0;
         c_w_en       <= 1'b0;
         c_addr       <= '0;
         c_di         <= '0;
      end else begin
         pend_clr     <= pend_clr_nxt;
         csr.csr_ack  <= csr_ack_nxt;
         csr.csr_err  <= csr_err_nxt;
         csr.csr_rdat <= csr_rdat_nxt;
         clr_busy     <= clr_busy_nxt;
         regf_busy    <= regf_busy_nxt;
         c_en         <= c_en_nxt;
         c_w_en       <= c_w_en_nxt;
         c_addr       <= c_addr_nxt;
         c_di         <= c_di_nxt;
      end
   end

endmodule

// File: tb/tb_pfpu_regf_ctl.sv
// tb/tb_pfpu_regf_ctl.sv - directed scoreboard bench for pfpu_regf_ctl

module tb_pfpu_regf_ctl;

   logic        sys_clk = 1'b0;
   logic        sys_rst = 1'b0;
   logic        alu_busy;
   logic        clr_start;
   logic        clr_busy;
   logic        regf_busy;
   logic        c_en;
   logic [6:0]  c_addr;
   logic        c_w_en;
   logic [31:0] c_di;
   logic [31:0] c_do = '0;

   pfpu_regf_ctl_if bus ();

   pfpu_regf_ctl #(
      .CLR_FIRST (2),
      .CLR_LAST  (127),
      .TIMEOUT   (16)
   ) dut (
      .sys_clk   (sys_clk),
      .sys_rst   (sys_rst),
      .csr       (bus),
      .alu_busy  (alu_busy),
      .clr_start (clr_start),
      .clr_busy  (clr_busy),
      .regf_busy (regf_busy),
      .c_en      (c_en),
      .c_addr    (c_addr),
      .c_w_en    (c_w_en),
      .c_di      (c_di),
      .c_do      (c_do)
   );

   always #5 sys_clk = ~sys_clk;

   // Register file model: registered read, R0/R1 read back overlay values.
   logic [31:0] mem [128];
   logic [31:0] r0_ovl;
   logic [31:0] r1_ovl;
   int          wr_cnt = 0;
   int          stray_cnt = 0;

   always @(posedge sys_clk) begin
      if (c_en) begin
         if (c_w_en) begin
            mem[c_addr] <= c_di;
            wr_cnt <= wr_cnt + 1;
            if (c_addr < 7'd2) stray_cnt <= stray_cnt + 1;
         end
         c_do <= (c_addr == 7'd0) ? r0_ovl : (c_addr == 7'd1) ? r1_ovl : mem[c_addr];
      end
   end

   typedef struct packed {
      logic [31:0] rdat;
      logic        err;
   } exp_t;

   exp_t        sb[$];
   logic [31:0] shadow [128];
   logic [31:0] last_rdat;
   logic        cur_we;
   logic [6:0]  cur_a;
   logic [31:0] cur_d;
   int          tests = 0;
   int          fails = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] exp_read(input logic [6:0] a);
      if (a == 7'd0) return r0_ovl;
      if (a == 7'd1) return r1_ovl;
      return shadow[a];
   endfunction

   task automatic clear_shadow();
      for (int i = 2; i < 128; i++) shadow[i] = '0;
   endtask

   // Moves one edge on (out of ACK if needed), pushes the expectation, raises csr_req.
   task automatic start_access(input logic we, input logic [6:0] a, input logic [31:0] d,
                               input logic exp_err);
      exp_t e;
      @(posedge sys_clk); #1;
      e.err = exp_err;
      if (exp_err) begin
         e.rdat = last_rdat;
      end else if (we) begin
         shadow[a] = d;
         e.rdat = last_rdat;
      end else begin
         e.rdat = exp_read(a);
         last_rdat = e.rdat;
      end
      sb.push_back(e);
      cur_we = we; cur_a = a; cur_d = d;
      bus.csr_we = we; bus.csr_addr = a; bus.csr_wdat = d; bus.csr_req = 1'b1;
   endtask

   task automatic finish_access(input int exp_lat, input logic chk_port, output int en_cycles);
      exp_t e;
      int   cyc;
      logic got;
      cyc = 0; got = 1'b0; en_cycles = 0;
      while (!got && cyc < 400) begin
         @(posedge sys_clk); #1;
         cyc++;
         if (c_en) en_cycles++;
         if (chk_port && cyc == 1) begin
            check("port_c_en", c_en, 1);
            check("port_c_w_en", c_w_en, cur_we);
            check("port_c_addr", c_addr, cur_a);
            if (cur_we) check("port_c_di", c_di, cur_d);
         end
         if (chk_port && cyc == 2) check("port_c_en_drop", c_en, 0);
         if (bus.csr_ack) got = 1'b1;
      end
      bus.csr_req = 1'b0;
      check("ack_seen", got, 1);
      if (exp_lat > 0) check("ack_latency", cyc, exp_lat);
      e = sb.pop_front();
      if (got) begin
         check("csr_rdat", bus.csr_rdat, e.rdat);
         check("csr_err", bus.csr_err, e.err);
      end
   endtask

   task automatic host_write(input logic [6:0] a, input logic [31:0] d);
      int en;
      start_access(1'b1, a, d, 1'b0);
      finish_access(2, 1'b1, en);
   endtask

   task automatic host_read(input logic [6:0] a);
      int en;
      start_access(1'b0, a, '0, 1'b0);
      finish_access(3, 1'b1, en);
   endtask

   task automatic wait_clear(output int cnt, output int first_cyc);
      int bad;
      bad = 0; cnt = 0; first_cyc = 0;
      for (int i = 1; i <= 400; i++) begin
         @(posedge sys_clk); #1;
         clr_start = 1'b0;
         if (clr_busy) begin
            if (cnt == 0) first_cyc = i;
            if (c_addr !== 7'(2 + cnt) || c_en !== 1'b1 || c_w_en !== 1'b1 ||
                c_di !== 32'd0 || regf_busy !== 1'b1) bad++;
            cnt++;
         end else if (cnt > 0) begin
            break;
         end
      end
      check("clear_port_bad_cycles", bad, 0);
      check("clear_busy_len", cnt, 126);
      check("clear_regf_busy_end", regf_busy, 0);
      clear_shadow();
   endtask

   initial begin
      int en, cnt, first, snap, seen;
      alu_busy = 1'b0; clr_start = 1'b0;
      bus.csr_req = 1'b0; bus.csr_we = 1'b0; bus.csr_addr = '0; bus.csr_wdat = '0;
      r0_ovl = 32'h12; r1_ovl = 32'h34; last_rdat = '0;
      for (int i = 0; i < 128; i++) shadow[i] = '0;

      // Reset state
      #2 sys_rst = 1'b1;
      repeat (2) @(posedge sys_clk);
      #1;
      check("rst_csr_ack", bus.csr_ack, 0);
      check("rst_csr_err", bus.csr_err, 0);
      check("rst_csr_rdat", bus.csr_rdat, 0);
      check("rst_clr_busy", clr_busy, 0);
      check("rst_regf_busy", regf_busy, 0);
      check("rst_c_en", c_en, 0);
      check("rst_c_w_en", c_w_en, 0);
      check("rst_c_addr", c_addr, 0);
      check("rst_c_di", c_di, 0);
      sys_rst = 1'b0;

      // Basic write/read latency and data
      host_write(7'd5, 32'h3F80_0000);
      host_read(7'd5);
      host_read(7'd0);
      host_read(7'd1);

      // Host write to R0 passes through to the regfile
      host_write(7'd0, 32'hDEAD_BEEF);
      check("r0_write_passes", stray_cnt, 1);
      host_write(7'd2, 32'h0000_0202);
      host_read(7'd2);

      // Read held off by alu_busy
      alu_busy = 1'b1;
      start_access(1'b0, 7'd5, '0, 1'b0);
      seen = 0;
      repeat (10) begin
         @(posedge sys_clk); #1;
         if (c_en) seen++;
         check("alu_hold_regf_busy", regf_busy, 0);
      end
      check("alu_hold_no_c_en", seen, 0);
      alu_busy = 1'b0;
      finish_access(3, 1'b1, en);

      // Fill, clear and read back R2..R127
      for (int a = 2; a < 128; a++) host_write(7'(a), 32'hFFFF_FFFF);
      snap = stray_cnt;
      @(posedge sys_clk); #1;
      clr_start = 1'b1;
      wait_clear(cnt, first);
      check("clear_first_cycle", first, 1);
      check("clear_no_r0_r1", stray_cnt, snap);
      for (int a = 2; a < 128; a++) host_read(7'(a));

      // clr_start during write ACK cycle
      host_write(7'd9, 32'h1234_5678);
      clr_start = 1'b1;
      wait_clear(cnt, first);
      check("ack_clr_first_cycle", first, 2);
      host_read(7'd9);

      // Simultaneous clr_start and csr_req: clear goes first
      host_write(7'd7, 32'h0000_0777);
      clear_shadow();
      start_access(1'b0, 7'd7, '0, 1'b0);
      clr_start = 1'b1;
      wait_clear(cnt, first);
      check("simul_clear_first", first, 1);
      finish_access(3, 1'b1, en);

      // Clear pending while alu_busy, serviced once it drops
      alu_busy = 1'b1;
      @(posedge sys_clk); #1;
      clr_start = 1'b1;
      @(posedge sys_clk); #1;
      clr_start = 1'b0;
      seen = 0;
      repeat (5) begin
         @(posedge sys_clk); #1;
         if (clr_busy) seen++;
      end
      check("pend_clr_held", seen, 0);
      alu_busy = 1'b0;
      wait_clear(cnt, first);
      check("pend_clr_first", first, 1);

`ifdef PFPU_REGF_CTL_TIMEOUT_EN
      // Request stuck behind alu_busy is aborted after TIMEOUT cycles
      alu_busy = 1'b1;
      start_access(1'b0, 7'd5, '0, 1'b1);
      finish_access(16, 1'b0, en);
      check("timeout_no_c_en", en, 0);
      alu_busy = 1'b0;
`endif

      // Nonzero read data so the reset visibly clears csr_rdat
      host_write(7'd6, 32'hA5A5_0001);
      host_read(7'd6);

      // Reset at clear cycle 40
      @(posedge sys_clk); #1;
      clr_start = 1'b1;
      cnt = 0;
      for (int i = 0; i < 200 && cnt < 40; i++) begin
         @(posedge sys_clk); #1;
         clr_start = 1'b0;
         if (clr_busy) cnt++;
      end
      check("rst_reached_cycle40", cnt, 40);
      #3 sys_rst = 1'b1;
      #1;
      check("mid_rst_clr_busy", clr_busy, 0);
      check("mid_rst_regf_busy", regf_busy, 0);
      check("mid_rst_c_en", c_en, 0);
      check("mid_rst_c_w_en", c_w_en, 0);
      check("mid_rst_c_addr", c_addr, 0);
      check("mid_rst_c_di", c_di, 0);
      check("mid_rst_csr_rdat", bus.csr_rdat, 0);
      check("mid_rst_csr_ack", bus.csr_ack, 0);
      snap = wr_cnt;
      repeat (2) @(posedge sys_clk);
      #1 sys_rst = 1'b0;
      last_rdat = '0;
      repeat (10) @(posedge sys_clk);
      #1;
      check("post_rst_no_writes", wr_cnt, snap);
      check("post_rst_clr_busy", clr_busy, 0);
      check("post_rst_regf_busy", regf_busy, 0);

      host_write(7'd5, 32'h4000_0000);
      host_read(7'd5);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
